// File: rtl/swi_debouncer_pkg.sv
// Shared constants for the switch debouncer.
package swi_debouncer_pkg;

   localparam int unsigned NBITS_TOP           = 8;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

   // Counter width able to hold values 0..debounce_cycles.
   function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/swi_debouncer_if.sv
// Switch bus and change-event handshake between the debouncer and its consumer.
interface swi_debouncer_if
   import swi_debouncer_pkg::*;
#(
   parameter int unsigned NBITS = NBITS_TOP
);

   logic [NBITS-1:0] SWI;
   logic [NBITS-1:0] swi_stable;
   logic [NBITS-1:0] swi_rise;
   logic [NBITS-1:0] swi_fall;
   logic             evt_valid;
   logic [NBITS-1:0] evt_data;
   logic             evt_ack;
   logic             evt_overflow;

   // Environment side: drives the raw switches and the acknowledge.
   modport master (
      output SWI, evt_ack,
      input  swi_stable, swi_rise, swi_fall, evt_valid, evt_data, evt_overflow
   );

   // Debouncer side.
   modport slave (
      input  SWI, evt_ack,
      output swi_stable, swi_rise, swi_fall, evt_valid, evt_data, evt_overflow
   );

endinterface

// File: rtl/swi_debouncer_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and stable level.
module debounce_bit
   import swi_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk_2,
   input  logic reset,
   input  logic swi_in,
   output logic stable_o
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive disagreeing samples; adopt the new level on the last one.
   always_comb begin
      sync1_d  = swi_in;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/swi_debouncer.sv
// Debounced switch bus with edge pulses and a single-entry change-event register.
module swi_debouncer
   import swi_debouncer_pkg::*;
#(
   parameter int unsigned NBITS           = NBITS_TOP,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input logic             clk_2,
   input logic             reset,
   swi_debouncer_if.slave  bus
);

   logic [NBITS-1:0] stable_w;
   logic [NBITS-1:0] rise_w;
   logic [NBITS-1:0] fall_w;
   logic [NBITS-1:0] stable_dly_q, stable_dly_d;
   logic             evt_valid_q, evt_valid_d;
   logic [NBITS-1:0] evt_data_q, evt_data_d;
   logic             evt_ovf_q, evt_ovf_d;
   logic             change;
   logic             accept;

   // Independent per-bit debouncers.
   for (genvar i = 0; i < int'(NBITS); i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk_2    (clk_2),
         .reset    (reset),
         .swi_in   (bus.SWI[i]),
         .stable_o (stable_w[i])
      );
   end

   assign rise_w = stable_w & ~stable_dly_q;
   assign fall_w = ~stable_w & stable_dly_q;

   // Event register: a change loads a snapshot; an unacked overwrite flags overflow.
   always_comb begin
      stable_dly_d = stable_w;
      evt_valid_d  = evt_valid_q;
      evt_data_d   = evt_data_q;
      evt_ovf_d    = evt_ovf_q;
      change       = |(rise_w | fall_w);
      accept       = evt_valid_q & bus.evt_ack;
      if (change) begin
         evt_valid_d = 1'b1;
         evt_data_d  = stable_w;
      end else if (accept) begin
         evt_valid_d = 1'b0;
      end
      if (accept) begin
         evt_ovf_d = 1'b0;
      end else if (change && evt_valid_q) begin
         evt_ovf_d = 1'b1;
      end
   end

   // Event and edge-detect registers with synchronous reset.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         stable_dly_q <= '0;
         evt_valid_q  <= 1'b0;
         evt_data_q   <= '0;
         evt_ovf_q    <= 1'b0;
      end else begin
         stable_dly_q <= stable_dly_d;
         evt_valid_q  <= evt_valid_d;
         evt_data_q   <= evt_data_d;
         evt_ovf_q    <= evt_ovf_d;
      end
   end

   assign bus.swi_stable   = stable_w;
   assign bus.swi_rise     = rise_w;
   assign bus.swi_fall     = fall_w;
   assign bus.evt_valid    = evt_valid_q;
   assign bus.evt_data     = evt_data_q;
   assign bus.evt_overflow = evt_ovf_q;

endmodule

// File: tb/tb_swi_debouncer.sv
// Self-checking bench for swi_debouncer (NBITS=8, DEBOUNCE_CYCLES=4).
module tb_swi_debouncer;

   localparam int unsigned NB = 8;
   localparam int unsigned DC = 4;

   logic clk;
   logic reset;

   swi_debouncer_if #(.NBITS(NB)) bus_if ();

   swi_debouncer #(
      .NBITS           (NB),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk_2 (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_evt  = 0;

   // Reference model: samples reach the debounce logic two edges late; a bit
   // flips once the last DC delivered samples all disagree with its stable level.
   logic [NB-1:0] m_sync[$];
   logic [NB-1:0] m_win[$];
   logic [NB-1:0] m_stable, m_dly, m_data;
   logic          m_valid, m_ovf;

   function automatic void model_reset();
      m_sync.delete();
      m_sync.push_back('0);
      m_sync.push_back('0);
      m_win.delete();
      for (int k = 0; k < int'(DC); k++) m_win.push_back('0);
      m_stable = '0;
      m_dly    = '0;
      m_data   = '0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
   endfunction

   function automatic void model_edge(input logic rst, input logic [NB-1:0] swi, input logic ack);
      logic [NB-1:0] used, new_st;
      logic          chg, acc, all_diff;
      if (rst) begin
         model_reset();
         return;
      end
      used = m_sync.pop_front();
      m_sync.push_back(swi);
      m_win.push_back(used);
      void'(m_win.pop_front());
      new_st = m_stable;
      for (int b = 0; b < int'(NB); b++) begin
         all_diff = 1'b1;
         foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
         if (all_diff) new_st[b] = ~m_stable[b];
      end
      chg = (m_stable != m_dly);
      acc = m_valid & ack;
      if (acc) m_ovf = 1'b0;
      else if (chg && m_valid) m_ovf = 1'b1;
      if (chg) begin
         m_valid = 1'b1;
         m_data  = m_stable;
      end else if (acc) begin
         m_valid = 1'b0;
      end
      m_dly    = m_stable;
      m_stable = new_st;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, advance the model, check after the rising edge.
   task automatic step(input logic rst, input logic [NB-1:0] swi, input logic ack);
      @(negedge clk);
      reset          = rst;
      bus_if.SWI     = swi;
      bus_if.evt_ack = ack;
      model_edge(rst, swi, ack);
      @(posedge clk);
      #1;
      chk("model_stable", 32'(bus_if.swi_stable), 32'(m_stable));
      chk("model_rise", 32'(bus_if.swi_rise), 32'(m_stable & ~m_dly));
      chk("model_fall", 32'(bus_if.swi_fall), 32'(~m_stable & m_dly));
      chk("model_valid", 32'(bus_if.evt_valid), 32'(m_valid));
      chk("model_data", 32'(bus_if.evt_data), 32'(m_data));
      chk("model_ovf", 32'(bus_if.evt_overflow), 32'(m_ovf));
      if ((bus_if.swi_rise | bus_if.swi_fall) != '0) n_evt++;
   endtask

   task automatic run(input int n, input logic [NB-1:0] swi, input logic ack);
      for (int i = 0; i < n; i++) step(1'b0, swi, ack);
   endtask

   typedef struct {
      logic          rst;
      logic [NB-1:0] swi;
      logic          ack;
      logic [NB-1:0] e_stable;
      logic [NB-1:0] e_rise;
      logic          e_valid;
      logic [NB-1:0] e_data;
      logic          e_ovf;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0] cur;
      logic          rr;
      reset          = 1'b1;
      bus_if.SWI     = '0;
      bus_if.evt_ack = 1'b0;
      model_reset();

      // Basic latency and event sequence with hand-derived expectations.
      tbl[0] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b0, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[6] = '{1'b0, 8'h01, 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0};
      tbl[7] = '{1'b0, 8'h01, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 1'b0};
      tbl[8] = '{1'b0, 8'h01, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 1'b0};
      tbl[9] = '{1'b0, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].swi, tbl[i].ack);
         chk($sformatf("tbl%0d_stable", i), 32'(bus_if.swi_stable), 32'(tbl[i].e_stable));
         chk($sformatf("tbl%0d_rise", i), 32'(bus_if.swi_rise), 32'(tbl[i].e_rise));
         chk($sformatf("tbl%0d_valid", i), 32'(bus_if.evt_valid), 32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_data", i), 32'(bus_if.evt_data), 32'(tbl[i].e_data));
         chk($sformatf("tbl%0d_ovf", i), 32'(bus_if.evt_overflow), 32'(tbl[i].e_ovf));
      end

      // Overwrite of an unacked snapshot sets overflow; ack clears both.
      run(7, 8'h81, 1'b0);
      chk("ovf_first_data", 32'(bus_if.evt_data), 32'h81);
      chk("ovf_first_ovf", 32'(bus_if.evt_overflow), 32'h0);
      run(6, 8'h80, 1'b0);
      chk("ovf_fall_pulse", 32'(bus_if.swi_fall), 32'h01);
      run(1, 8'h80, 1'b0);
      chk("ovf_data", 32'(bus_if.evt_data), 32'h80);
      chk("ovf_set", 32'(bus_if.evt_overflow), 32'h1);
      step(1'b0, 8'h80, 1'b1);
      chk("ovf_ack_valid", 32'(bus_if.evt_valid), 32'h0);
      chk("ovf_ack_ovf", 32'(bus_if.evt_overflow), 32'h0);
      step(1'b0, 8'h80, 1'b1);
      chk("idle_ack_valid", 32'(bus_if.evt_valid), 32'h0);
      chk("idle_ack_data", 32'(bus_if.evt_data), 32'h80);

      // Accept coinciding with a change cycle keeps valid and suppresses overflow.
      run(7, 8'h00, 1'b0);
      chk("coin_pre_valid", 32'(bus_if.evt_valid), 32'h1);
      run(6, 8'h01, 1'b0);
      chk("coin_rise", 32'(bus_if.swi_rise), 32'h01);
      step(1'b0, 8'h01, 1'b1);
      chk("coin_valid", 32'(bus_if.evt_valid), 32'h1);
      chk("coin_data", 32'(bus_if.evt_data), 32'h01);
      chk("coin_ovf", 32'(bus_if.evt_overflow), 32'h0);

      // Short glitch on bit 2 is rejected.
      step(1'b1, 8'h00, 1'b0);
      n_evt = 0;
      run(2, 8'h00, 1'b0);
      run(3, 8'h04, 1'b0);
      run(8, 8'h00, 1'b0);
      chk("glitch_stable", 32'(bus_if.swi_stable), 32'h00);
      chk("glitch_valid", 32'(bus_if.evt_valid), 32'h0);
      chk("glitch_pulses", 32'(n_evt), 32'd0);

      // Reset mid-count discards progress; full window restarts from zero.
      step(1'b1, 8'hFF, 1'b0);
      run(4, 8'hFF, 1'b0);
      chk("rmid_pre_stable", 32'(bus_if.swi_stable), 32'h00);
      step(1'b1, 8'hFF, 1'b0);
      chk("rmid_rst_stable", 32'(bus_if.swi_stable), 32'h00);
      chk("rmid_rst_rise", 32'(bus_if.swi_rise), 32'h00);
      run(5, 8'hFF, 1'b0);
      chk("rmid_5_stable", 32'(bus_if.swi_stable), 32'h00);
      run(1, 8'hFF, 1'b0);
      chk("rmid_6_stable", 32'(bus_if.swi_stable), 32'hFF);
      chk("rmid_6_rise", 32'(bus_if.swi_rise), 32'hFF);
      run(1, 8'hFF, 1'b0);
      chk("rmid_valid", 32'(bus_if.evt_valid), 32'h1);
      chk("rmid_data", 32'(bus_if.evt_data), 32'hFF);

      // Bit 0 chattering every cycle while bit 7 is held high.
      step(1'b1, 8'h00, 1'b0);
      n_evt = 0;
      for (int i = 0; i < 20; i++) step(1'b0, 8'h80 | 8'(i & 1), 1'b0);
      run(10, 8'h80, 1'b0);
      chk("chat_stable", 32'(bus_if.swi_stable), 32'h80);
      chk("chat_events", 32'(n_evt), 32'd1);
      chk("chat_data", 32'(bus_if.evt_data), 32'h80);

      // Randomized traffic against the model: sparse bit flips, random acks, rare resets.
      cur = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) cur = cur ^ (NB'($urandom) & NB'($urandom));
         rr = ($urandom_range(0, 199) == 0);
         step(rr, cur, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/swi_debouncer.md
SWI_DEBOUNCER -- requirements
Module: swi_debouncer

Interface
REQ-001 The module SHALL have parameter NBITS, default NBITS_TOP (8), giving the switch bus width.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the stability window in clk_2 cycles; legal range is 1..255.
REQ-003 clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SWI  input  NBITS  raw, asynchronous switch levels.
REQ-006 swi_stable  output  NBITS  debounced switch levels.
REQ-007 swi_rise  output  NBITS  one-cycle pulse per bit on a stable 0->1 transition.
REQ-008 swi_fall  output  NBITS  one-cycle pulse per bit on a stable 1->0 transition.
REQ-009 evt_valid  output  1  a change snapshot is pending.
REQ-010 evt_data  output  NBITS  snapshot of swi_stable taken at the latest change.
REQ-011 evt_ack  input  1  consumer accepts the pending snapshot.
REQ-012 evt_overflow  output  1  a snapshot was overwritten before it was accepted.

Function
REQ-013 Each SWI bit SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-014 Each bit SHALL have a counter of width $clog2(DEBOUNCE_CYCLES+1), handled per edge as follows:
- counter clears when sync2 equals the stable bit;
- counter increments when they differ;
- when the increment would reach DEBOUNCE_CYCLES, the stable bit takes sync2 and the counter clears.
REQ-015 Latency: a level held on SWI SHALL appear on swi_stable exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that sampled it.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave swi_stable unchanged and the counter cleared.
REQ-017 Bits SHALL debounce independently; simultaneous changes on several bits SHALL each follow REQ-014.
REQ-018 swi_rise SHALL equal swi_stable & ~stable_d, and swi_fall SHALL equal ~swi_stable & stable_d.
- stable_d is swi_stable delayed one cycle.
- Each pulse is high for exactly the one cycle after the stable update.
REQ-019 A change cycle is any cycle in which (swi_rise | swi_fall) is nonzero; on the next edge evt_data SHALL load swi_stable and evt_valid SHALL go to 1.
REQ-020 An accept occurs when evt_valid and evt_ack are both high at an edge; with no change cycle, evt_valid SHALL clear at that edge.
REQ-021 If an accept and a change cycle coincide, evt_valid SHALL stay 1, evt_data SHALL load the new value, and evt_overflow SHALL NOT be set.
REQ-022 If a change cycle occurs while evt_valid=1 without evt_ack, evt_data SHALL be overwritten with the new value and evt_overflow SHALL be set.
REQ-023 evt_overflow SHALL stay set until the next accept, at which edge it clears.
REQ-024 evt_ack asserted while evt_valid=0 SHALL be ignored.
REQ-025 evt_data SHALL hold its value while evt_valid=0.

Reset
REQ-026 While reset is high at an edge, all of the following SHALL clear to 0: sync1, sync2, counters, swi_stable, stable_d, evt_valid, evt_data, evt_overflow.
REQ-027 swi_rise and swi_fall SHALL therefore read 0 in the cycle after reset.
REQ-028 Reset mid-debounce SHALL discard the partial count.
REQ-029 A nonzero SWI held through reset SHALL be re-debounced from stable=0 and SHALL produce rise pulses and an event.
REQ-030 Reset SHALL take priority over evt_ack and over any change cycle.

Structure
REQ-031 NBITS_TOP and the default debounce window constant SHALL live in the shared top-level package.
REQ-032 One-bit synchronizer plus counter plus stable register SHALL be a sub-module, debounce_bit, instantiated NBITS times in a generate loop.
REQ-033 The event handshake logic SHALL reside in swi_debouncer.

Verification (DEBOUNCE_CYCLES=4, NBITS=8)
REQ-034 Reset, then SWI=8'h01 from edge 1 -> swi_stable=8'h01 after edge 6, swi_rise=8'h01 for one cycle, evt_valid=1 after edge 7 with evt_data=8'h01.
REQ-035 SWI bit 2 pulses high for 3 cycles then returns low -> swi_stable stays 8'h00, no rise/fall pulses, evt_valid stays 0.
REQ-036 Stable 8'h01, then SWI=8'h81 with no ack, then later 8'h80 -> evt_data=8'h80, evt_overflow=1; ack -> evt_valid=0 and evt_overflow=0 next edge.
REQ-037 evt_ack high in the same cycle as a new change cycle -> evt_valid stays 1, evt_data holds the new value, evt_overflow=0.
REQ-038 Reset pulsed at counter value 2 with SWI=8'hFF held -> swi_stable=8'h00 after reset, then 8'hFF exactly 6 edges later, swi_rise=8'hFF, evt_valid=1.
REQ-039 SWI toggles bit 0 every cycle for 20 cycles, with bit 7 held high -> only bit 7 becomes stable; exactly one event is raised, with evt_data=8'h80.
